// File: rtl/bitblender_pkg.sv
// Shared types for the bitblender wave path: writer FSM states and byte width.
package bitblender_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } wave_writer_state_t;

endpackage

// File: rtl/wave_writer_sample_assembler.sv
// Collects little-endian bytes into one sample; full_out marks the byte that completes it.
module sample_assembler
  import bitblender_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    clear_in,
  input  logic                    accept_in,
  input  logic [BYTE_WIDTH-1:0]   byte_in,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    full_out
);

  localparam int BYTES = SAMPLE_WIDTH / BYTE_WIDTH;
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BYTES - 1);

  logic [CW-1:0] r_count;

  assign full_out = accept_in && (r_count == LAST_IDX);

  always_ff @(posedge clk_in) begin
    if (!rst_in || clear_in) begin
      r_count <= '0;
    end else if (accept_in) begin
      r_count <= full_out ? '0 : r_count + CW'(1);
    end
  end

  // Bytes enter at the top and shift down, so byte 0 ends up in the low bits.
  generate
    if (BYTES == 1) begin : g_single
      assign sample_out = byte_in;
    end else begin : g_multi
      localparam int HW = SAMPLE_WIDTH - BYTE_WIDTH;
      logic [HW-1:0]           r_hold;
      logic [SAMPLE_WIDTH-1:0] w_cat;

      assign w_cat      = {byte_in, r_hold};
      assign sample_out = w_cat;

      always_ff @(posedge clk_in) begin
        if (!rst_in || clear_in) begin
          r_hold <= '0;
        end else if (accept_in) begin
          r_hold <= w_cat[SAMPLE_WIDTH-1:BYTE_WIDTH];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/wave_writer.sv
// Streams bytes into main wave memory as samples and pulses a trigger once the wave is complete.
module wave_writer
  import bitblender_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int BRAM_DEPTH     = 4096,
  parameter int WW_WIDTH       = 12,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic [WW_WIDTH-1:0]     wave_width_in,
  input  logic [BYTE_WIDTH-1:0]   byte_in,
  input  logic                    byte_valid_in,
  output logic                    byte_ready_out,
  output logic [WW_WIDTH-1:0]     mem_addr_out,
  output logic [SAMPLE_WIDTH-1:0] mem_data_out,
  output logic                    mem_we_out,
  output logic                    busy_out,
  output logic                    done_trig_out,
  output logic                    error_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]     TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW_WIDTH:0] DEPTH_W = (WW_WIDTH + 1)'(BRAM_DEPTH);
  localparam logic [WW_WIDTH:0] ONE_W   = (WW_WIDTH + 1)'(1);

  wave_writer_state_t      r_state;
  logic [WW_WIDTH:0]       r_width;
  logic [WW_WIDTH-1:0]     r_addr;
  logic [TW-1:0]           r_tcount;
  logic                    r_error;
  logic [SAMPLE_WIDTH-1:0] r_mem_data;

  logic                    w_accept;
  logic                    w_start_ok;
  logic                    w_timeout;
  logic                    w_full;
  logic                    w_last;
  logic [SAMPLE_WIDTH-1:0] w_sample;
  logic [WW_WIDTH:0]       w_width_ext;
  logic [WW_WIDTH:0]       w_width_clamped;
  logic [WW_WIDTH:0]       w_addr_next;

  assign w_accept    = byte_valid_in && (r_state == RECV);
  assign w_start_ok  = (r_state == IDLE) && start_in && (wave_width_in != '0);
  assign w_timeout   = (r_state == RECV) && !w_accept && (r_tcount == TO_LAST);
  assign w_width_ext = {1'b0, wave_width_in};
  assign w_width_clamped = (w_width_ext > DEPTH_W) ? DEPTH_W : w_width_ext;
  // One extra bit so a full-depth width still compares against addr+1 without wrapping.
  assign w_addr_next = {1'b0, r_addr} + ONE_W;
  assign w_last      = (w_addr_next == r_width);

  sample_assembler #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_assembler (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clear_in   (w_start_ok || w_timeout),
    .accept_in  (w_accept),
    .byte_in    (byte_in),
    .sample_out (w_sample),
    .full_out   (w_full)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= IDLE;
      r_width    <= '0;
      r_addr     <= '0;
      r_tcount   <= '0;
      r_error    <= 1'b0;
      r_mem_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_width  <= w_width_clamped;
            r_addr   <= '0;
            r_tcount <= '0;
            r_error  <= 1'b0;
            r_state  <= RECV;
          end else if (start_in) begin
            r_error <= 1'b1;
          end
        end
        RECV: begin
          if (w_full) begin
            r_mem_data <= w_sample;
            r_tcount   <= '0;
            r_state    <= WRITE;
          end else if (w_accept) begin
            r_tcount <= '0;
          end else if (w_timeout) begin
            r_tcount <= '0;
            r_error  <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_tcount <= r_tcount + TW'(1);
          end
        end
        WRITE: begin
          if (w_last) begin
            r_state <= DONE;
          end else begin
            r_addr  <= w_addr_next[WW_WIDTH-1:0];
            r_state <= RECV;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign byte_ready_out = (r_state == RECV);
  assign mem_we_out     = (r_state == WRITE);
  assign done_trig_out  = (r_state == DONE);
  assign busy_out       = (r_state != IDLE);
  assign mem_addr_out   = r_addr;
  assign mem_data_out   = r_mem_data;
  assign error_out      = r_error;

endmodule
